// File: rtl/lab5_pkg.sv
// Shared definitions for the lab5 8-to-3 debounced encoder: FSM states, default
// debounce length and the priority-encode helper.
package lab5_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StHold,
        StRelease
    } state_t;

    localparam int unsigned DEB_CYCLES_DEF = 4;

    // Highest set bit wins; an all-zero input encodes as 0.
    function automatic logic [2:0] prio_enc8(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/lab5_sync2.sv
// Two-flop synchronizer for the raw switch lines; both stages clear on reset.
module lab5_sync2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/lab5_enc8to3.sv
// Debounced 8-to-3 priority encoder with hold/acknowledge handshake.
// Define LAB5_ENC_MULTI_EN to add the multi output (more than one line active).
module lab5_enc8to3
    import lab5_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic       ack,
    output logic       A0,
    output logic       A1,
    output logic       A2,
`ifdef LAB5_ENC_MULTI_EN
    output logic       multi,
`endif
    output logic       valid
);

    localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

    logic [7:0] ss;
    state_t     state_q;
    logic [7:0] cnt_q;
    logic [7:0] snap_q;
    logic [2:0] code_q;
    logic       valid_q;

    lab5_sync2 #(
        .WIDTH(8)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(sw),
        .q_o(ss)
    );

`ifdef LAB5_ENC_MULTI_EN
    logic multi_q;
    logic snap_multi;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign snap_multi = (snap_q & (snap_q - 8'd1)) != 8'd0;
    assign multi      = multi_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            snap_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
`ifdef LAB5_ENC_MULTI_EN
            multi_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (ss != 8'd0) begin
                        state_q <= StSettle;
                        snap_q  <= ss;
                        cnt_q   <= '0;
                    end
                end
                StSettle: begin
                    if (ss == 8'd0) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (ss != snap_q) begin
                        // A different pattern restarts the debounce window.
                        snap_q <= ss;
                        cnt_q  <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= StHold;
                        code_q  <= prio_enc8(snap_q);
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
`ifdef LAB5_ENC_MULTI_EN
                        multi_q <= snap_multi;
`endif
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StHold: begin
                    if (ack) begin
                        state_q <= StRelease;
                        valid_q <= 1'b0;
                        code_q  <= '0;
                        cnt_q   <= '0;
`ifdef LAB5_ENC_MULTI_EN
                        multi_q <= 1'b0;
`endif
                    end
                end
                StRelease: begin
                    // Lines must read all-zero for the full window before re-arming.
                    if (ss != 8'd0) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign A0    = code_q[0];
    assign A1    = code_q[1];
    assign A2    = code_q[2];
    assign valid = valid_q;

endmodule

// File: tb/tb_lab5_enc8to3.sv
// Bench for lab5_enc8to3: directed scenarios then random switch activity, all
// checked every cycle against a run-length reference model of the encoder.
module tb_lab5_enc8to3;

    localparam int DEB = 4;

    logic       clk;
    logic       rst;
    logic [7:0] sw;
    logic       ack;
    logic       A0;
    logic       A1;
    logic       A2;
    logic       valid;
`ifdef LAB5_ENC_MULTI_EN
    logic       multi;
`endif

    lab5_enc8to3 #(
        .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw(sw),
        .ack(ack),
        .A0(A0),
        .A1(A1),
        .A2(A2),
`ifdef LAB5_ENC_MULTI_EN
        .multi(multi),
`endif
        .valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a code is accepted when the line pattern seen by the
    // logic (sw delayed two edges) stays the same nonzero value for DEB+1
    // consecutive armed edges; re-arming needs DEB all-zero edges after ack.
    typedef enum {MArmed, MHold, MRel} mmode_t;
    mmode_t     m_mode;
    logic [7:0] hist[$];
    logic [7:0] run_val;
    int         run_len;
    int         zeros;
    logic       e_valid;
    logic [2:0] e_code;
    logic       e_multi;

    function automatic logic [2:0] top_bit(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_mode  = MArmed;
        run_val = 8'd0;
        run_len = 0;
        zeros   = 0;
        e_valid = 1'b0;
        e_code  = 3'd0;
        e_multi = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] s, input logic a);
        logic [7:0] seen;
        hist.push_back(s);
        if (hist.size() > 3) void'(hist.pop_front());
        seen = (hist.size() == 3) ? hist[0] : 8'd0;
        case (m_mode)
            MArmed: begin
                if (seen == 8'd0) run_len = 0;
                else if (run_len > 0 && seen == run_val) run_len++;
                else begin
                    run_val = seen;
                    run_len = 1;
                end
                if (run_len == DEB + 1) begin
                    m_mode  = MHold;
                    e_valid = 1'b1;
                    e_code  = top_bit(run_val);
                    e_multi = ($countones(run_val) >= 2);
                    run_len = 0;
                end
            end
            MHold: begin
                if (a) begin
                    m_mode  = MRel;
                    zeros   = 0;
                    e_valid = 1'b0;
                    e_code  = 3'd0;
                    e_multi = 1'b0;
                end
            end
            default: begin
                zeros = (seen == 8'd0) ? zeros + 1 : 0;
                if (zeros == DEB) begin
                    m_mode  = MArmed;
                    run_len = 0;
                end
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, {7'd0, valid}, {7'd0, e_valid});
        chk({tag, "_code"}, {5'd0, A2, A1, A0}, {5'd0, e_code});
`ifdef LAB5_ENC_MULTI_EN
        chk({tag, "_multi"}, {7'd0, multi}, {7'd0, e_multi});
`endif
    endtask

    // Called at a negedge: drive, clock once, check, return at the next negedge.
    task automatic step(input logic [7:0] s, input logic a, input string tag);
        sw  = s;
        ack = a;
        @(posedge clk);
        model_edge(s, a);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic hold(input logic [7:0] s, input int n, input string tag);
        for (int i = 0; i < n; i++) step(s, 1'b0, tag);
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sw  = 8'd0;
        ack = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // Single line: valid exactly on edge 7, then one ack, no second code while held.
        for (int i = 1; i <= 10; i++) begin
            step(8'h01, 1'b0, "r030");
            if (i == 6) chk("r030_e6_valid", {7'd0, valid}, 8'd0);
            if (i == 7) begin
                chk("r030_e7_valid", {7'd0, valid}, 8'd1);
                chk("r030_e7_code", {5'd0, A2, A1, A0}, 8'd0);
            end
        end
        step(8'h01, 1'b1, "r030_ack");
        chk("r030_ack_valid", {7'd0, valid}, 8'd0);
        hold(8'h01, 20, "r030_held");
        hold(8'h00, 8, "r030_rel");

        // Several lines: highest index wins.
        hold(8'h2C, 8, "r031");
        chk("r031_code", {5'd0, A2, A1, A0}, 8'd5);
`ifdef LAB5_ENC_MULTI_EN
        chk("r031_multi", {7'd0, multi}, 8'd1);
`endif
        step(8'h00, 1'b1, "r031_ack");
        hold(8'h00, 8, "r031_rel");

        // Glitch too short to accept.
        hold(8'h08, 2, "r032");
        hold(8'h00, 10, "r032_idle");
        chk("r032_valid", {7'd0, valid}, 8'd0);

        // Pattern change restarts the window.
        hold(8'h02, 3, "r033_a");
        for (int i = 1; i <= 8; i++) begin
            step(8'h80, 1'b0, "r033_b");
            if (i == 6) chk("r033_e6_valid", {7'd0, valid}, 8'd0);
            if (i == 7) chk("r033_e7_code", {4'd0, valid, A2, A1, A0}, 8'h0F);
        end
        step(8'h00, 1'b1, "r033_ack");
        hold(8'h00, 8, "r033_rel");

        // Reset drops a held code immediately, then full latency again.
        hold(8'h08, 8, "r034_a");
        chk("r034_held", {4'd0, valid, A2, A1, A0}, 8'h0B);
        pulse_reset("r034_rst");
        chk("r034_rst_out", {4'd0, valid, A2, A1, A0}, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            step(8'h04, 1'b0, "r034_b");
            if (i == 6) chk("r034_e6_valid", {7'd0, valid}, 8'd0);
            if (i == 7) chk("r034_e7_code", {4'd0, valid, A2, A1, A0}, 8'h0A);
        end
        step(8'h04, 1'b1, "r034_ack");
        hold(8'h00, 8, "r034_rel");

        // Release window: three zero cycles are not enough, four are.
        hold(8'h10, 8, "r035_a");
        step(8'h10, 1'b1, "r035_ack");
        hold(8'h00, 3, "r035_z3");
        hold(8'h10, 12, "r035_b");
        chk("r035_stay_valid", {7'd0, valid}, 8'd0);
        hold(8'h00, 4, "r035_z4");
        hold(8'h10, 8, "r035_c");
        chk("r035_code", {4'd0, valid, A2, A1, A0}, 8'h0C);
        step(8'h00, 1'b1, "r035_ack2");
        hold(8'h00, 8, "r035_rel");

        // Random switch activity with random acks and occasional resets.
        for (int n = 0; n < 300; n++) begin
            logic [7:0] v;
            int         len;
            case ($urandom_range(0, 3))
                0:       v = 8'd0;
                1:       v = 8'd1 << $urandom_range(0, 7);
                default: v = 8'($urandom);
            endcase
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) begin
                step(v, ($urandom_range(0, 3) == 0), "rand");
            end
            if ($urandom_range(0, 49) == 0) pulse_reset("rand_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lab5_enc8to3.md
LAB5_ENC8TO3 -- requirements
Module: lab5_enc8to3

Interface
REQ-001 Parameter DEB_CYCLES, default 4, number of consecutive stable sampled cycles required before a code is accepted (legal range 2..255).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 sw  input  8  raw switch/line inputs, asynchronous to clk; sw[i] high means line i active.
REQ-005 ack  input  1  consumer acknowledge; consumes the held code when sampled high in HOLD.
REQ-006 A0  output  1  encoded index bit 0 (LSB); bit order matches the lab5 3-to-8 decoder inputs.
REQ-007 A1  output  1  encoded index bit 1.
REQ-008 A2  output  1  encoded index bit 2 (MSB).
REQ-009 valid  output  1  {A2,A1,A0} holds an accepted code.
REQ-010 multi  output  1  more than one sw line active when the code was accepted (present only under REQ-026).

Function
REQ-011 sw SHALL pass through a two-flop synchronizer; all logic uses the synchronized value (ss).
REQ-012 FSM states SHALL be IDLE, SETTLE, HOLD, RELEASE; reset state IDLE.
REQ-013 IDLE: ss != 0 -> SETTLE, snapshot <= ss, cnt <= 0; otherwise remain.
REQ-014 SETTLE: ss == 0 -> IDLE; ss != snapshot -> snapshot <= ss, cnt <= 0, remain; else cnt increments.
REQ-015 SETTLE: when cnt == DEB_CYCLES-1 and ss == snapshot -> HOLD; {A2,A1,A0} <= index of highest set bit of snapshot; valid <= 1.
REQ-016 Priority SHALL be highest index wins (sw[7] over sw[6] ... over sw[0]).
REQ-017 Latency: sw stable nonzero from edge 1 SHALL give valid high after edge DEB_CYCLES+3 (7 for default).
REQ-018 HOLD: outputs frozen; sw changes ignored; ack high -> valid <= 0, {A2,A1,A0} <= 0, go RELEASE.
REQ-019 ack sampled in IDLE, SETTLE or RELEASE SHALL be ignored.
REQ-020 RELEASE: cnt counts consecutive cycles with ss == 0, reset to 0 on any ss != 0; at cnt == DEB_CYCLES-1 -> IDLE.
REQ-021 A held input SHALL never produce a second code; a new code requires passing RELEASE first.
REQ-022 cnt width SHALL be 8 bits; it never wraps, as it stops at DEB_CYCLES-1.

Reset
REQ-023 rst high SHALL immediately force: state IDLE, valid 0, A2/A1/A0 0, multi 0, cnt 0, snapshot 0, synchronizer flops 0.
REQ-024 rst asserted in any state, including HOLD with valid high, SHALL discard the pending code; no ack required.
REQ-025 After rst deasserts, the first code SHALL require the full REQ-017 latency.

Configuration
REQ-026 Macro LAB5_ENC_MULTI_EN defined: multi port exists, set at the REQ-015 transition when snapshot has two or more set bits and cleared with valid.
REQ-027 Macro absent: multi port and its popcount logic SHALL not exist; all other behaviour unchanged.

Structure
REQ-028 Shared package lab5_pkg SHALL hold the FSM state typedef, the DEB_CYCLES default constant and the 8-to-3 priority-encode function.
REQ-029 Synchronizer SHALL be a separate sub-module lab5_sync2, 8 bits wide, instantiated once.

Verification (DEB_CYCLES=4)
REQ-030 sw=0x01 held -> valid=1, A=000 after edge 7; ack pulse -> valid=0 next edge; no second valid while sw held.
REQ-031 sw=0x2C -> A=101 (bit 5); multi=1 with LAB5_ENC_MULTI_EN, port absent without it.
REQ-032 sw=0x08 for 2 cycles, then 0 -> valid never asserts; FSM back in IDLE.
REQ-033 sw=0x02 for 3 cycles, then 0x80 -> debounce restarts; A=111 valid on edge 7 after the change.
REQ-034 valid=1, A=011, rst pulsed -> valid=0, A=000 immediately; after release sw=0x04 -> A=010 after 7 edges.
REQ-035 After ack, sw=0 for 3 cycles, then 0x10 -> remain in RELEASE; sw=0 for 4 cycles, then 0x10 -> A=100.
